acc_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit accumulator (`clock`/`reset`/`update`/`in`/`out` datapath) between several requesters. Each requester asks for a sum of a fixed number of operands. The scheduler grants one requester, clears the accumulator, and streams that requester's operands into it with a valid/ready handshake. It then returns the registered sum tagged with the requester index. It sits between the requester blocks and the single accumulator instance.

---
 rtl/acc_sched_pkg.sv | 18 +
 rtl/acc_sched_rr_arbiter.sv | 34 +++
 rtl/acc_sched.sv | 155 +++++++++++++++
 tb/tb_acc_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg -- shared constants for the accumulator scheduler.
//   Default widths (DW, LENW, NREQ) and the FSM state encoding used by
//   acc_sched.
package acc_sched_pkg;

    localparam int DW_DEF   = 8;
    localparam int LENW_DEF = 4;
    localparam int NREQ_DEF = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/acc_sched_rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//   req    : per-requester request levels
//   ptr    : index searched first; search proceeds upward and wraps
//   win    : one-hot winner (all zero when no request)
//   win_id : index of the winner
//   any    : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_id,
    output logic            any
);

    always_comb begin
        int idx;
        idx    = 0;
        win    = '0;
        win_id = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                win[idx] = 1'b1;
                win_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/acc_sched.sv
// acc_sched -- round-robin scheduler sharing one external accumulator.
//   Grants one requester, clears the accumulator, streams that requester's
//   operands into it with valid/ready, then returns the registered sum tagged
//   with the requester index.
// Ports:
//   clock, reset        : clock (rising edge), async active-low reset
//   req, req_len        : per-requester request level and operand count
//   op_valid, op_data   : per-requester operand stream
//   op_ready, gnt       : one-hot handshake ready / grant
//   acc_clear, acc_update, acc_in, acc_out : accumulator control/data
//   done, result, result_id, ovf           : completion pulse and result
// Configuration macro: ACC_SCHED_SAT_EN -- when defined, an overflowing
//   transaction returns all-ones and raises ovf; otherwise the result wraps
//   and ovf is constant 0.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*LENW-1:0]     req_len,
    input  logic [NREQ-1:0]          op_valid,
    input  logic [NREQ*DW-1:0]       op_data,
    output logic [NREQ-1:0]          op_ready,
    output logic [NREQ-1:0]          gnt,
    output logic                     acc_clear,
    output logic                     acc_update,
    output logic [DW-1:0]            acc_in,
    input  logic [DW-1:0]            acc_out,
    output logic                     done,
    output logic [DW-1:0]            result,
    output logic [$clog2(NREQ)-1:0]  result_id,
    output logic                     ovf
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic [NREQ-1:0] cur_oh;
    logic [LENW-1:0] cnt;

    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_id;
    logic            any;

    logic [IW-1:0]   cur_inc;
    logic [DW-1:0]   cur_data;
    logic            accept;
    logic [DW-1:0]   drain_val;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .win    (win),
        .win_id (win_id),
        .any    (any)
    );

    // NREQ need not be a power of two, so wrap explicitly.
    assign cur_inc  = (cur == IW'(NREQ - 1)) ? '0 : cur + 1'b1;
    assign cur_data = op_data[cur*DW +: DW];

    // An operand is only taken while the owner still holds its request; a
    // dropped request in the same cycle is an abort, not a final add.
    assign accept = (state == S_FEED) && req[cur] && op_valid[cur];

    // Handshake/grant outputs depend on state and latched owner only, so
    // op_ready never combinationally follows op_valid.
    assign gnt        = (state != S_IDLE) ? cur_oh : '0;
    assign op_ready   = (state == S_FEED) ? cur_oh : '0;
    assign acc_clear  = (state == S_CLEAR);
    assign acc_update = accept;
    assign acc_in     = accept ? cur_data : '0;
    assign done       = (state == S_DONE);

`ifdef ACC_SCHED_SAT_EN
    logic          ovf_q;
    logic [DW:0]   sum;

    // Mirror of the add the accumulator performs this cycle; the carry-out
    // marks the transaction as overflowed.
    assign sum       = {1'b0, acc_out} + {1'b0, acc_in};
    assign drain_val = ovf_q ? '1 : acc_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == S_CLEAR)
                ovf_q <= 1'b0;
            else if (accept && sum[DW])
                ovf_q <= 1'b1;
            if (state == S_DRAIN)
                ovf <= ovf_q;
        end
    end
`else
    assign drain_val = acc_out;
    assign ovf       = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur       <= '0;
            cur_oh    <= '0;
            cnt       <= '0;
            result    <= '0;
            result_id <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any) begin
                        cur    <= win_id;
                        cur_oh <= win;
                        cnt    <= req_len[win_id*LENW +: LENW];
                        state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state <= (cnt != '0) ? S_FEED : S_DRAIN;
                end
                S_FEED: begin
                    if (!req[cur]) begin
                        ptr   <= cur_inc;
                        state <= S_IDLE;
                    end else if (accept) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LENW'(1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    result    <= drain_val;
                    result_id <= cur;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    ptr   <= cur_inc;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched -- self-checking bench for acc_sched with a behavioural
//   accumulator. Single-requester transactions come from a vector table;
//   arbitration order, pointer wrap, mid-FEED reset and abort are
//   hand-written sequences. Results are checked by a done-driven scoreboard.
module tb_acc_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int LENW = 4;
`ifdef ACC_SCHED_SAT_EN
    localparam int SAT = 1;
`else
    localparam int SAT = 0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*LENW-1:0] req_len = '0;
    logic [NREQ-1:0]      op_valid = '0;
    logic [NREQ*DW-1:0]   op_data = '0;
    logic [NREQ-1:0]      op_ready;
    logic [NREQ-1:0]      gnt;
    logic                 acc_clear;
    logic                 acc_update;
    logic [DW-1:0]        acc_in;
    logic [DW-1:0]        acc_out;
    logic                 done;
    logic [DW-1:0]        result;
    logic [1:0]           result_id;
    logic                 ovf;
    logic [DW-1:0]        acc_model = '0;

    acc_sched #(.NREQ(NREQ), .DW(DW), .LENW(LENW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_len(req_len),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .gnt(gnt), .acc_clear(acc_clear), .acc_update(acc_update),
        .acc_in(acc_in), .acc_out(acc_out), .done(done), .result(result),
        .result_id(result_id), .ovf(ovf)
    );

    always #5 clock = ~clock;

    // External accumulator: synchronous clear, add on update, no reset.
    always @(posedge clock) begin
        if (acc_clear)       acc_model <= '0;
        else if (acc_update) acc_model <= acc_model + acc_in;
    end
    assign acc_out = acc_model;

    typedef struct {
        int             id;
        int             len;
        logic [3:0][7:0] ops;
        logic [7:0]     vpat;
        int             res;
        int             ovf;
        int             dcyc;
    } vec_t;

    typedef struct {
        int res;
        int id;
        int ovf;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_result", int'(result), e.res);
                check("sb_result_id", int'(result_id), e.id);
                check("sb_ovf", int'(ovf), e.ovf);
            end
        end
    end

    task automatic push_exp(input int res, input int id, input int o);
        exp_t e;
        e.res = res; e.id = id; e.ovf = o;
        sb.push_back(e);
    endtask

    // One single-requester transaction; cycle c counts from the first edge
    // that sees req high.
    task automatic run_vec(input vec_t v);
        int k, fi, dc, nupd;
        repeat (2) @(posedge clock);
        #1;
        push_exp(v.res, v.id, v.ovf);
        req_len[v.id*LENW +: LENW] = LENW'(v.len);
        req[v.id] = 1'b1;
        k = 0; fi = 0; dc = -1; nupd = 0;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(posedge clock);
            #1;
            op_valid = '0;
            if (c == 1) begin
                check("clear_cycle1", int'(acc_clear), 1);
                check("gnt_cycle1", int'(gnt), 1 << v.id);
            end
            if (op_ready[v.id]) begin
                op_valid[v.id] = (fi < 8) ? v.vpat[fi] : 1'b1;
                op_data[v.id*DW +: DW] = v.ops[k];
                fi++;
            end
            #1;
            if (acc_update) begin
                check("acc_in", int'(acc_in), int'(v.ops[k]));
                if (k < 3) k++;
                nupd++;
            end
            if (done) begin
                dc = c;
                req[v.id] = 1'b0;
            end
        end
        op_valid = '0;
        req[v.id] = 1'b0;
        check("done_cycle", dc, v.dcyc);
        check("update_count", nupd, v.len);
    endtask

    // Serve every granted requester continuously until n_want dones.
    task automatic serve(input int n_want, input string nm, output int fg);
        int nd;
        nd = 0;
        fg = 0;
        for (int c = 0; c < 60 && nd < n_want; c++) begin
            @(posedge clock);
            #1;
            if (fg == 0 && gnt != '0) fg = int'(gnt);
            op_valid = op_ready;
            #1;
            if (done) begin
                req[result_id] = 1'b0;
                nd++;
            end
        end
        op_valid = '0;
        check(nm, nd, n_want);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, int'(gnt), 0);
        check({tag, "_op_ready"}, int'(op_ready), 0);
        check({tag, "_acc_clear"}, int'(acc_clear), 0);
        check({tag, "_acc_update"}, int'(acc_update), 0);
        check({tag, "_acc_in"}, int'(acc_in), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_result_id"}, int'(result_id), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
    endtask

    initial begin
        int fg;
        int found;

        vecs[0] = '{id:0, len:3, ops:{8'd0, 8'd26, 8'd15, 8'd2}, vpat:8'hFF,
                    res:43, ovf:0, dcyc:6};
        vecs[1] = '{id:2, len:0, ops:32'd0, vpat:8'hFF,
                    res:0, ovf:0, dcyc:3};
        vecs[2] = '{id:3, len:2, ops:{8'd0, 8'd0, 8'd100, 8'd200}, vpat:8'hFF,
                    res:(SAT != 0) ? 255 : 44, ovf:SAT, dcyc:5};
        vecs[3] = '{id:1, len:2, ops:{8'd0, 8'd0, 8'd9, 8'd5}, vpat:8'h09,
                    res:14, ovf:0, dcyc:7};
        vecs[4] = '{id:1, len:4, ops:{8'd4, 8'd3, 8'd2, 8'd1}, vpat:8'hFF,
                    res:10, ovf:0, dcyc:7};
        vecs[5] = '{id:0, len:1, ops:{8'd0, 8'd0, 8'd0, 8'd255}, vpat:8'hFF,
                    res:255, ovf:0, dcyc:4};

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;

        // Round-robin: 1010 from ptr 0 serves 1 then 3
        op_data[1*DW +: DW] = 8'd7;
        op_data[3*DW +: DW] = 8'd9;
        req_len[1*LENW +: LENW] = 4'd1;
        req_len[3*LENW +: LENW] = 4'd1;
        push_exp(7, 1, 0);
        push_exp(9, 3, 0);
        req = 4'b1010;
        serve(2, "arb_ndone", fg);
        check("arb_first_gnt", fg, 2);

        // Pointer wrapped to 0: 0011 serves 0 first
        req_len[0*LENW +: LENW] = 4'd0;
        req_len[1*LENW +: LENW] = 4'd0;
        push_exp(0, 0, 0);
        push_exp(0, 1, 0);
        req = 4'b0011;
        serve(2, "wrap_ndone", fg);
        check("wrap_first_gnt", fg, 1);

        // Table of single-requester transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset during FEED after one operand was accumulated
        @(posedge clock);
        #1;
        req_len[0*LENW +: LENW] = 4'd3;
        op_data[0*DW +: DW] = 8'd50;
        req = 4'b0001;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(posedge clock);
            #1;
            if (op_ready[0]) found = 1;
        end
        check("rst_feed_reached", found, 1);
        op_valid = 4'b0001;
        @(posedge clock);
        #1;
        op_valid = '0;
        reset = 1'b0;
        req = '0;
        #1;
        check_zero_outputs("midreset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_vec(vecs[0]);

        // Abort: requester 2 drops req in FEED, requester 1 is served next
        @(posedge clock);
        #1;
        req_len[2*LENW +: LENW] = 4'd2;
        req = 4'b0100;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(posedge clock);
            #1;
            if (op_ready[2]) found = 1;
        end
        check("abort_feed_reached", found, 1);
        req_len[1*LENW +: LENW] = 4'd1;
        op_data[1*DW +: DW] = 8'd33;
        push_exp(33, 1, 0);
        req = 4'b0010;
        serve(1, "abort_ndone", fg);
        check("abort_next_gnt", fg, 2);

        repeat (3) @(posedge clock);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
